// File: rtl/gate_array_regs.sv
// CPC Gate Array register file: pens, inks, mode/ROM control, RAM config.
// GA_MODE_HSYNC_LATCH_EN: defer mode changes to the next hsync falling edge.
module gate_array_regs #(
  parameter logic [4:0] INK_RESET  = 5'd20,
  parameter logic [1:0] MODE_RESET = 2'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        hsync_n,
  input  logic [3:0]  pen,
  output logic [4:0]  color,
  output logic [4:0]  border_color,
  output logic [1:0]  mode,
  output logic        int_clear,
  output logic        rom_lo_dis,
  output logic        rom_hi_dis,
  output logic [2:0]  ram_config
);

  logic       ga_sel;
  logic       wr_pen;
  logic       wr_ink;
  logic       wr_ctrl;
  logic       wr_ram;
  logic       sel_border;
  logic [3:0] sel_pen;
  logic [4:0] border_ink;
  logic [1:0] mode_pending;
  logic [4:0] ink [16];

  assign ga_sel = cpu_wr && (cpu_addr[15:14] == 2'b01);

  always_comb begin
    wr_pen  = 1'b0;
    wr_ink  = 1'b0;
    wr_ctrl = 1'b0;
    wr_ram  = 1'b0;
    if (ga_sel) begin
      unique case (cpu_data[7:6])
        2'b00: wr_pen  = 1'b1;
        2'b01: wr_ink  = 1'b1;
        2'b10: wr_ctrl = 1'b1;
        2'b11: wr_ram  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_border   <= 1'b0;
      sel_pen      <= 4'd0;
      border_ink   <= INK_RESET;
      mode_pending <= MODE_RESET;
      rom_lo_dis   <= 1'b0;
      rom_hi_dis   <= 1'b0;
      ram_config   <= 3'd0;
      int_clear    <= 1'b0;
    end else begin
      int_clear <= wr_ctrl && cpu_data[4];
      if (wr_pen) begin
        sel_border <= cpu_data[4];
        sel_pen    <= cpu_data[3:0];
      end
      if (wr_ink && sel_border)
        border_ink <= cpu_data[4:0];
      if (wr_ctrl) begin
        mode_pending <= cpu_data[1:0];
        rom_lo_dis   <= cpu_data[2];
        rom_hi_dis   <= cpu_data[3];
      end
      if (wr_ram)
        ram_config <= cpu_data[2:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        ink[i] <= INK_RESET;
    end else if (wr_ink && !sel_border) begin
      ink[sel_pen] <= cpu_data[4:0];
    end
  end

  assign color        = ink[pen];
  assign border_color = border_ink;

`ifdef GA_MODE_HSYNC_LATCH_EN
  logic hsync_prev;
  logic hs_fall;

  assign hs_fall = hsync_prev && !hsync_n;

  // A control write landing on the edge itself wins over the stale pending value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_prev <= 1'b1;
      mode       <= MODE_RESET;
    end else begin
      hsync_prev <= hsync_n;
      if (hs_fall)
        mode <= wr_ctrl ? cpu_data[1:0] : mode_pending;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[13:0], cpu_data[5]};
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mode <= MODE_RESET;
    else if (wr_ctrl)
      mode <= cpu_data[1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[13:0], cpu_data[5], hsync_n, mode_pending};
`endif

endmodule

// File: tb/tb_gate_array_regs.sv
// Self-checking bench for gate_array_regs: per-cycle model compare
// plus hand-computed directed expectations.
module tb_gate_array_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        hsync_n = 1'b1;
  logic [3:0]  pen = 4'd0;
  logic [4:0]  color;
  logic [4:0]  border_color;
  logic [1:0]  mode;
  logic        int_clear;
  logic        rom_lo_dis;
  logic        rom_hi_dis;
  logic [2:0]  ram_config;

  int checks = 0;
  int errors = 0;

  gate_array_regs dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_wr       (cpu_wr),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .hsync_n      (hsync_n),
    .pen          (pen),
    .color        (color),
    .border_color (border_color),
    .mode         (mode),
    .int_clear    (int_clear),
    .rom_lo_dis   (rom_lo_dis),
    .rom_hi_dis   (rom_hi_dis),
    .ram_config   (ram_config)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the Gate Array state must be
  int m_ink [16];
  int m_border;
  int m_pen_sel;
  bit m_bsel;
  int m_mode;
  int m_pend;
  bit m_int;
  bit m_lo;
  bit m_hi;
  int m_ram;
  bit m_hs_last;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ink[i] = 20;
    m_border = 20;
    m_pen_sel = 0;
    m_bsel = 0;
    m_mode = 1;
    m_pend = 1;
    m_int = 0;
    m_lo = 0;
    m_hi = 0;
    m_ram = 0;
    m_hs_last = 1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      bit acc;
      int fn;
      int nmode;
      acc = cpu_wr && (cpu_addr[15:14] == 2'b01);
      fn = cpu_data[7:6];
      nmode = m_mode;
      m_int = acc && fn == 2 && cpu_data[4];
`ifdef GA_MODE_HSYNC_LATCH_EN
      if (m_hs_last && !hsync_n)
        nmode = (acc && fn == 2) ? int'(cpu_data[1:0]) : m_pend;
`else
      if (acc && fn == 2) nmode = cpu_data[1:0];
`endif
      if (acc) begin
        if (fn == 0) begin
          m_bsel = cpu_data[4];
          m_pen_sel = cpu_data[3:0];
        end else if (fn == 1) begin
          if (m_bsel) m_border = cpu_data[4:0];
          else m_ink[m_pen_sel] = cpu_data[4:0];
        end else if (fn == 2) begin
          m_pend = cpu_data[1:0];
          m_lo = cpu_data[2];
          m_hi = cpu_data[3];
        end else begin
          m_ram = cpu_data[2:0];
        end
      end
      m_mode = nmode;
      m_hs_last = hsync_n;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare away from the active edge
  always @(negedge clk) begin
    chk("m_color", color, m_ink[pen]);
    chk("m_border", border_color, m_border);
    chk("m_mode", mode, m_mode);
    chk("m_int_clear", int_clear, m_int);
    chk("m_rom_lo", rom_lo_dis, m_lo);
    chk("m_rom_hi", rom_hi_dis, m_hi);
    chk("m_ram", ram_config, m_ram);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_data = d;
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b0;
    tick();

    for (int p = 0; p < 16; p++) begin
      pen = 4'(p);
      #1;
      chk("rst_color", color, 20);
      tick();
    end
    chk("rst_border", border_color, 20);
    chk("rst_mode", mode, 1);
    chk("rst_int", int_clear, 0);
    chk("rst_ram", ram_config, 0);
    chk("rst_rom", {rom_hi_dis, rom_lo_dis}, 0);

    wr(16'h7F00, 8'h03);
    pen = 4'd3;
    wr(16'h7F00, 8'h4B);
    chk("ink3", color, 11);
    pen = 4'd2;
    #1;
    chk("ink2_keep", color, 20);
    pen = 4'd3;
    wr(16'h7F00, 8'h6C);
    chk("ink3_again_b5", color, 12);

    wr(16'h7F00, 8'h10);
    wr(16'h7F00, 8'h46);
    chk("border6", border_color, 6);
    chk("ink3_unch", color, 12);

    hsync_n = 1'b1;
    tick();
    wr(16'h7F00, 8'h82);
`ifdef GA_MODE_HSYNC_LATCH_EN
    chk("mode_hold", mode, 1);
    hsync_n = 1'b0;
    tick();
    chk("mode_fall", mode, 2);
    hsync_n = 1'b1;
    tick();
    hsync_n = 1'b0;
    wr(16'h7F00, 8'h81);
    chk("mode_coinc", mode, 1);
`else
    chk("mode_direct", mode, 2);
    hsync_n = 1'b0;
    wr(16'h7F00, 8'h81);
    chk("mode_direct2", mode, 1);
`endif
    hsync_n = 1'b1;
    tick();

    wr(16'h7F00, 8'h9C);
    chk("int_pulse", int_clear, 1);
    chk("rom_lo", rom_lo_dis, 1);
    chk("rom_hi", rom_hi_dis, 1);
    tick();
    chk("int_end", int_clear, 0);
    wr(16'h7F00, 8'h90);
    wr(16'h7F00, 8'h90);
    chk("int_b2b", int_clear, 1);
    wr(16'h7F00, 8'h8C);
    chk("int_b2b_end", int_clear, 0);

    wr(16'hBF00, 8'h9C);
    chk("bf_int", int_clear, 0);
    wr(16'hBF00, 8'hC7);
    chk("bf_ram", ram_config, 0);
    wr(16'h3F00, 8'h00);
    wr(16'hFF00, 8'h5F);
    chk("ff_ink", color, 12);

    wr(16'h7F00, 8'hC5);
    chk("ram5", ram_config, 5);

    #2;
    reset = 1'b1;
    #1;
    chk("arst_color", color, 20);
    chk("arst_border", border_color, 20);
    chk("arst_mode", mode, 1);
    chk("arst_ram", ram_config, 0);
    chk("arst_rom", {rom_hi_dis, rom_lo_dis}, 0);
    chk("arst_int", int_clear, 0);
    tick();
    tick();
    #3;
    reset = 1'b0;
    tick();
    hsync_n = 1'b0;
    tick();
    hsync_n = 1'b1;
    tick();
    chk("post_rst_mode", mode, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
